// File: rtl/operand_fetch_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_pkg
//   Shared defaults for the operand fetch stage and its busy scoreboard.
//   ADDR_W_DEF   : register address width
//   DATA_W_DEF   : register data width
//   OP_W_DEF     : opaque opcode width (carried through untouched)
//   NUM_REGS_DEF : register count for the default address width (2^ADDR_W)
//   num_regs()   : register count for an arbitrary address width
// -----------------------------------------------------------------------------
package operand_fetch_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;
  localparam int OP_W_DEF     = 4;
  localparam int NUM_REGS_DEF = 1 << ADDR_W_DEF;

  function automatic int num_regs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// -----------------------------------------------------------------------------
// scoreboard
//   One busy bit per architectural register. A set bit means a write to that
//   register has been issued and its writeback has not been seen yet.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   set_en, set_addr    : mark set_addr busy at the edge (issue of a writer)
//   clr_en, clr_addr    : mark clr_addr free at the edge (writeback)
//   q1/q2/q3_addr       : query addresses
//   q1/q2/q3_busy       : busy state of the query addresses, already treating a
//                         same-cycle writeback to that address as free
//
// A set and a clear to the same address on the same edge leaves the bit set:
// the newly issued writer owns the register after that edge.
// -----------------------------------------------------------------------------
module scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  input  logic [ADDR_W-1:0] q3_addr,
  output logic              q1_busy,
  output logic              q2_busy,
  output logic              q3_busy
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  logic [NUM_REGS-1:0] busy;

  // Clear is applied first so that a same-edge set to the same address wins.
  // Reset has priority over both, so a writeback during reset is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (clr_en) begin
        busy[clr_addr] <= 1'b0;
      end
      if (set_en) begin
        busy[set_addr] <= 1'b1;
      end
    end
  end

  // A writeback landing this cycle resolves the hazard now: its data is
  // forwarded by the fetch stage, so the register is effectively free.
  assign q1_busy = busy[q1_addr] && !(clr_en && (clr_addr == q1_addr));
  assign q2_busy = busy[q2_addr] && !(clr_en && (clr_addr == q2_addr));
  assign q3_busy = busy[q3_addr] && !(clr_en && (clr_addr == q3_addr));

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//   Single-entry issue stage between decode and execute. It reads both source
//   operands from a combinational register file, forwards a same-cycle
//   writeback, stalls on RAW/WAW hazards tracked by a busy scoreboard, and
//   registers the issued operation for one cycle of latency.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     : upstream instruction handshake
//   in_op, in_rs1, in_rs2,
//   in_rd                   : opcode, source and destination addresses
//   r1_addr, r2_addr        : register file read addresses (= in_rs1/in_rs2)
//   r1_out, r2_out          : register file read data
//   wb_write, wb_addr,
//   wb_data                 : writeback bus (shared with register file write)
//   out_valid / out_ready   : downstream operation handshake
//   out_op, out_rd,
//   out_a, out_b            : registered opcode, destination, operands
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge. in_ready is a function of the current inputs and state (it drops on
// a hazard, during reset, or when the output register is full and stalled);
// out_valid/out_* are registers and never depend combinationally on
// out_ready.
// -----------------------------------------------------------------------------
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  output logic [ADDR_W-1:0] r1_addr,
  output logic [ADDR_W-1:0] r2_addr,
  input  logic [DATA_W-1:0] r1_out,
  input  logic [DATA_W-1:0] r2_out,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  logic              rs1_busy;
  logic              rs2_busy;
  logic              rd_busy;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  assign r1_addr = in_rs1;
  assign r2_addr = in_rs2;

  // The busy outputs already exclude a same-cycle writeback, so an
  // instruction waiting on that register issues in the writeback cycle.
  // rd is checked too, which keeps writes to one register in order (WAW).
  scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (accept),
    .set_addr (in_rd),
    .clr_en   (wb_write),
    .clr_addr (wb_addr),
    .q1_addr  (in_rs1),
    .q2_addr  (in_rs2),
    .q3_addr  (in_rd),
    .q1_busy  (rs1_busy),
    .q2_busy  (rs2_busy),
    .q3_busy  (rd_busy)
  );

  assign hazard   = in_valid && (rs1_busy || rs2_busy || rd_busy);
  assign in_ready = !reset && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Writeback bypass: the register file only shows wb_data after the edge.
  always_comb begin
    op1 = r1_out;
    op2 = r2_out;
    if (wb_write && (wb_addr == in_rs1)) begin
      op1 = wb_data;
    end
    if (wb_write && (wb_addr == in_rs2)) begin
      op2 = wb_data;
    end
  end

  // Output register stage. Data only moves on accept; a drain without a new
  // accept just drops out_valid and leaves the payload as it was.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op    <= in_op;
      out_rd    <= in_rd;
      out_a     <= op1;
      out_b     <= op2;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//   Directed and short random stimulus for operand_fetch paired with a
//   combinational-read register file. Issued operations are predicted into
//   exp_q when accepted and compared when they leave the output register;
//   in_ready is predicted from an independent busy model every cycle.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int NREGS  = 1 << ADDR_W;
  localparam int EXP_W  = OP_W + ADDR_W + 2 * DATA_W;

  // ---------------------------------------------------------------- signals
  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] r1_addr;
  logic [ADDR_W-1:0] r2_addr;
  logic [DATA_W-1:0] r1_out;
  logic [DATA_W-1:0] r2_out;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic [ADDR_W-1:0] out_rd;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [NREGS-1:0] model_busy = '0;

  // ------------------------------------------------------- clock and reset
  always #5 clock = ~clock;

  // --------------------------------------------------------------- reg_file
  logic [DATA_W-1:0] rf [NREGS];
  logic              rf_loaded = 1'b0;

  function automatic logic [DATA_W-1:0] rf_init(input int i);
    logic [DATA_W-1:0] v;
    v = DATA_W'(i) ^ 8'hA5;
    if (i == 10) v = 8'h55;
    if (i == 11) v = 8'h05;
    return v;
  endfunction

  always @(posedge clock) begin
    if (!rf_loaded) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= rf_init(i);
      rf_loaded <= 1'b1;
    end else if (wb_write) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign r1_out = rf[r1_addr];
  assign r2_out = rf[r2_addr];

  // -------------------------------------------------------------------- dut
  operand_fetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .r1_addr   (r1_addr),
    .r2_addr   (r2_addr),
    .r1_out    (r1_out),
    .r2_out    (r2_out),
    .wb_write  (wb_write),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_rd    (out_rd),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  // ------------------------------------------------------------ check/model
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hz(input logic [ADDR_W-1:0] a);
    return model_busy[a] && !(wb_write && (wb_addr == a));
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic drive_in(input logic v, input logic [OP_W-1:0] op,
                          input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                          input logic [ADDR_W-1:0] rd);
    in_valid = v;
    in_op    = op;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
  endtask

  task automatic drive_wb(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_write = w;
    wb_addr  = a;
    wb_data  = d;
  endtask

  // One cycle: called just after a falling edge with inputs driven. Predicts
  // the handshakes, scores any leaving operation, then advances to the next
  // falling edge.
  task automatic tick();
    logic             m_out_valid;
    logic             exp_ready;
    logic             acc;
    logic [EXP_W-1:0] item;
    logic [EXP_W-1:0] e;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    #1;
    m_out_valid = (exp_q.size() != 0);
    exp_ready = !reset
             && !(in_valid && (model_hz(in_rs1) || model_hz(in_rs2) || model_hz(in_rd)))
             && (!m_out_valid || out_ready);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_out_valid));
    acc  = in_valid && exp_ready;
    a    = (wb_write && (wb_addr == in_rs1)) ? wb_data : rf[in_rs1];
    b    = (wb_write && (wb_addr == in_rs2)) ? wb_data : rf[in_rs2];
    item = {in_op, in_rd, a, b};
    if (m_out_valid && out_ready) begin
      e = exp_q.pop_front();
      check("out_data", 32'({out_op, out_rd, out_a, out_b}), 32'(e));
    end
    if (reset) begin
      exp_q.delete();
      model_busy = '0;
    end else begin
      if (wb_write) model_busy[wb_addr] = 1'b0;
      if (acc) begin
        model_busy[in_rd] = 1'b1;
        exp_q.push_back(item);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive_in(1'b0, '0, '0, '0, '0);
    drive_wb(1'b0, '0, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_fields", 32'({out_op, out_rd, out_a, out_b}), 32'd0);
    check("reset_busy", 32'(|dut.u_scoreboard.busy), 32'd0);
    reset = 1'b0;

    // Simple issue
    drive_in(1'b1, 4'h3, 8'd10, 8'd11, 8'd20);
    #1;
    check("s1_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive_in(1'b0, '0, '0, '0, '0);
    #1;
    check("s1_out_valid", 32'(out_valid), 32'd1);
    check("s1_out_a", 32'(out_a), 32'h55);
    check("s1_out_b", 32'(out_b), 32'h05);
    check("s1_out_rd", 32'(out_rd), 32'd20);
    check("s1_busy20", 32'(dut.u_scoreboard.busy[20]), 32'd1);

    // RAW stall on r20, released by a forwarded writeback
    drive_in(1'b1, 4'h5, 8'd20, 8'd11, 8'd21);
    #1;
    check("raw_stall0", 32'(in_ready), 32'd0);
    tick();
    #1;
    check("raw_stall1", 32'(in_ready), 32'd0);
    tick();
    drive_wb(1'b1, 8'd20, 8'hFF);
    #1;
    check("raw_wb_ready", 32'(in_ready), 32'd1);
    tick();
    drive_wb(1'b0, '0, '0);
    drive_in(1'b0, '0, '0, '0, '0);
    #1;
    check("raw_out_a_fwd", 32'(out_a), 32'hFF);
    check("raw_out_rd", 32'(out_rd), 32'd21);
    check("raw_busy20_clr", 32'(dut.u_scoreboard.busy[20]), 32'd0);

    // Backpressure with a new instruction waiting
    out_ready = 1'b0;
    drive_in(1'b1, 4'h7, 8'd1, 8'd2, 8'd40);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", 32'({out_op, out_rd, out_a, out_b}), 32'({4'h5, 8'd21, 8'hFF, 8'h05}));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    drive_in(1'b0, '0, '0, '0, '0);
    #1;
    check("bp_next_rd", 32'(out_rd), 32'd40);
    check("bp_next_a", 32'(out_a), 32'hA4);
    check("bp_next_b", 32'(out_b), 32'hA7);
    tick();

    // Same-edge set and clear of r15
    drive_in(1'b1, 4'h1, 8'd3, 8'd4, 8'd15);
    tick();
    drive_in(1'b0, '0, '0, '0, '0);
    #1;
    check("sc_busy15_set", 32'(dut.u_scoreboard.busy[15]), 32'd1);
    tick();
    drive_in(1'b1, 4'h2, 8'd5, 8'd15, 8'd15);
    drive_wb(1'b1, 8'd15, 8'h3C);
    #1;
    check("sc_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive_in(1'b0, '0, '0, '0, '0);
    drive_wb(1'b0, '0, '0);
    #1;
    check("sc_busy15_kept", 32'(dut.u_scoreboard.busy[15]), 32'd1);
    check("sc_out_a", 32'(out_a), 32'hA0);
    check("sc_out_b_fwd", 32'(out_b), 32'h3C);
    tick();

    // WAW on r30
    drive_in(1'b1, 4'h4, 8'd6, 8'd7, 8'd30);
    tick();
    drive_in(1'b0, '0, '0, '0, '0);
    tick();
    drive_in(1'b1, 4'h6, 8'd8, 8'd9, 8'd30);
    #1;
    check("waw_stall0", 32'(in_ready), 32'd0);
    tick();
    #1;
    check("waw_stall1", 32'(in_ready), 32'd0);
    tick();
    drive_wb(1'b1, 8'd30, 8'h77);
    #1;
    check("waw_release", 32'(in_ready), 32'd1);
    tick();
    drive_in(1'b0, '0, '0, '0, '0);
    drive_wb(1'b0, '0, '0);
    #1;
    check("waw_out_rd", 32'(out_rd), 32'd30);
    check("waw_busy30", 32'(dut.u_scoreboard.busy[30]), 32'd1);
    tick();

    // Reset mid-stream with a held output and a pending writer of r20
    out_ready = 1'b0;
    drive_in(1'b1, 4'h9, 8'd12, 8'd13, 8'd20);
    tick();
    drive_in(1'b0, '0, '0, '0, '0);
    #1;
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    check("rst_pre_busy20", 32'(dut.u_scoreboard.busy[20]), 32'd1);
    reset = 1'b1;
    drive_wb(1'b1, 8'd15, 8'h99);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    drive_wb(1'b0, '0, '0);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fields", 32'({out_op, out_rd, out_a, out_b}), 32'd0);
    check("rst_busy_all", 32'(|dut.u_scoreboard.busy), 32'd0);
    drive_in(1'b1, 4'hA, 8'd20, 8'd10, 8'd22);
    #1;
    check("rst_accept_r20", 32'(in_ready), 32'd1);
    tick();
    drive_in(1'b0, '0, '0, '0, '0);
    #1;
    check("rst_out_a", 32'(out_a), 32'hFF);
    check("rst_out_b", 32'(out_b), 32'h55);
    tick();

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 80; i++) begin
      drive_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
               8'($urandom_range(0, 7)));
      drive_wb(1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 7)),
               8'($urandom_range(0, 255)));
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain: every accepted operation must have left exactly once
    drive_in(1'b0, '0, '0, '0, '0);
    drive_wb(1'b0, '0, '0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
